dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port round-robin arbiter and access sequencer in front of data_memory.
- Port 0 is the core load/store stage; port 1 is the debug/DMA loader.
- Each port uses a valid/ready request and a valid/ready response. Accepted requests are latched, driven to the memory for exactly one cycle, and the read data is registered before it is returned.
- Writes into the ROM region are blocked and reported as errors.

Parameters:
- DATA_WIDTH, RISC_V_DATA_WIDTH (common_pkg): width of write and read data.
- ADDR_WIDTH, DATA_MEMORY_ADDRESS_WIDTH (common_pkg): word address width.
- ROM_DEPTH, DATA_MEMORY_ROM_DEPTH (common_pkg): addresses below this value are read-only.
- CNT_WIDTH, 16: width of the grant counters (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- p0_req_valid  in  1  port 0 request valid.
- p0_req_ready  out  1  port 0 request accepted this cycle.
- p0_req_we  in  1  1 = write, 0 = read.
- p0_req_addr  in  ADDR_WIDTH  word address.
- p0_req_wdata  in  DATA_WIDTH  write data.
- p0_rsp_valid  out  1  port 0 response valid.
- p0_rsp_ready  in  1  port 0 response consumed.
- p0_rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- p0_rsp_err  out  1  rejected ROM-region write.
- p1_*  (same set)  port 1, identical to p0_*.
- mem_address  out  ADDR_WIDTH  to data_memory address.
- mem_w_data  out  DATA_WIDTH  to data_memory w_data.
- mem_r_data  in  DATA_WIDTH  from data_memory r_data.
- mem_ctrl_mem_w  out  1  memory write strobe.
- mem_ctrl_mem_r  out  1  memory read strobe.
- busy  out  1  high whenever the FSM is not in IDLE.
- grant_cnt_0  out  CNT_WIDTH  port 0 grant count.
- grant_cnt_1  out  CNT_WIDTH  port 1 grant count.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE; last_grant = 1, so port 0 wins the first tie.
  - All pN_req_ready, pN_rsp_valid, pN_rsp_err, pN_rsp_rdata = 0.
  - All mem_* outputs = 0; busy = 0; counters = 0.
- FSM has three states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If exactly one port has valid, grant it.
  - If both have valid, grant the port that is not last_grant.
  - pN_req_ready is asserted combinationally for the granted port only, and only in IDLE.
  - On the handshake: latch we, addr, wdata and the grant id, update last_grant, go to ACCESS.
  - With no valid request, stay in IDLE and keep mem_* at 0.
- ACCESS (exactly 1 cycle):
  - mem_address = latched address.
  - Read: mem_ctrl_mem_r = 1; mem_r_data is registered into the response data.
  - Write with addr >= ROM_DEPTH: mem_ctrl_mem_w = 1 and mem_w_data = wdata; rdata = 0; err = 0.
  - Write with addr < ROM_DEPTH: no strobe; rdata = 0; err = 1.
  - Always go to RESP.
- RESP:
  - The granted port's rsp_valid = 1, and rdata/err are held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE and clear rsp_valid on the next edge.
  - The other port's rsp_valid stays 0.
- Latency: from request handshake (cycle 0) to rsp_valid is 2 cycles. Maximum throughput is one access per 3 cycles.
- Only one outstanding access at a time. No request is accepted outside IDLE; requesters hold valid and the arbiter holds ready low.
- Strobes are mutually exclusive and asserted only in ACCESS. mem_* outputs are registered or decoded from the state, and are glitch-free at the memory.
- Reset mid-operation: any access or response in flight is dropped. If reset lands during ACCESS with a write, the memory may or may not have been written; requesters must reissue.
- Address compare is unsigned at full ADDR_WIDTH. Address ROM_DEPTH itself is writable.

Optional Feature:
- Macro: DMEM_ARBITER_GRANT_CNT_EN.
- Defined:
  - grant_cnt_0 and grant_cnt_1 increment on each accepted request of their port.
  - Counters saturate at all-ones and reset to 0.
  - They are not cleared by any other event.
- Undefined:
  - No counter logic is built; grant_cnt_0 and grant_cnt_1 are tied to 0.
  - The port list is unchanged.

Test Plan:
- Single read: ROM word 0x05 preloaded with 0xDEADBEEF; p0 read addr 0x05 -> p0_req_ready in the same cycle; mem_ctrl_mem_r = 1 for exactly 1 cycle; p0_rsp_valid 2 cycles later with rdata 0xDEADBEEF and err = 0.
- Write then read RAM: p1 writes 0x12345678 to ROM_DEPTH+3, then reads it back -> mem_ctrl_mem_w pulses once, read returns 0x12345678, err = 0 on both responses.
- ROM write protection: p0 writes 0xFFFFFFFF to addr 0x02 -> no mem_ctrl_mem_w pulse; p0_rsp_err = 1; a subsequent read of 0x02 returns the original ROM value.
- Round-robin fairness: both ports hold valid for 6 back-to-back requests each with rsp_ready tied high -> grants alternate p0, p1, p0, ...; each access takes 3 cycles; counters read 6/6 when the feature is enabled and 0/0 when disabled.
- Response backpressure: p0 read with p0_rsp_ready low for 5 cycles while p1 is valid -> p0 response held stable; p1_req_ready stays 0 until the p0 response handshakes, then p1 is granted in IDLE.
- Reset mid-access: assert rst_n low during ACCESS of a p1 read -> all outputs 0 immediately; after release, last_grant = 1 and the first tie goes to p0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and access sequencer in front of
// data_memory. Port 0 is the core load/store stage, port 1 the debug/DMA
// loader. One access is in flight at a time: IDLE (arbitrate) -> ACCESS (one
// memory cycle) -> RESP (hold response until consumed). Writes below ROM_DEPTH
// are blocked and answered with err = 1.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   pN_req_valid/ready          request handshake (ready is combinational, IDLE only)
//   pN_req_we/addr/wdata        request payload
//   pN_rsp_valid/ready          response handshake
//   pN_rsp_rdata/err            response payload (rdata 0 for writes)
//   mem_address/w_data/r_data   data_memory interface
//   mem_ctrl_mem_w/mem_r        data_memory strobes (registered, ACCESS only)
//   busy                        FSM not in IDLE
//   grant_cnt_0/1               saturating per-port grant counters
//
// Optional feature: define DMEM_ARBITER_GRANT_CNT_EN to build the grant
// counters; otherwise grant_cnt_0/1 are tied to 0.

module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned ROM_DEPTH  = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_we,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [DATA_WIDTH-1:0] p0_req_wdata,
  output logic                  p0_rsp_valid,
  input  logic                  p0_rsp_ready,
  output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
  output logic                  p0_rsp_err,

  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_req_we,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  input  logic [DATA_WIDTH-1:0] p1_req_wdata,
  output logic                  p1_rsp_valid,
  input  logic                  p1_rsp_ready,
  output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
  output logic                  p1_rsp_err,

  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_w_data,
  input  logic [DATA_WIDTH-1:0] mem_r_data,
  output logic                  mem_ctrl_mem_w,
  output logic                  mem_ctrl_mem_r,

  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  grant_cnt_0,
  output logic [CNT_WIDTH-1:0]  grant_cnt_1
);

  // One extra bit so a ROM_DEPTH of 2**ADDR_WIDTH still compares correctly.
  localparam int unsigned CMP_WIDTH = ADDR_WIDTH + 1;
  localparam logic [CMP_WIDTH-1:0] ROM_LIMIT = CMP_WIDTH'(ROM_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                  last_grant;
  logic                  lat_id;
  logic                  lat_we;
  logic                  lat_rom;

  logic                  gnt_id;
  logic                  req_hs;
  logic                  rsp_hs;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_rom;

  // Payload of the port that would win arbitration this cycle.
  assign sel_we    = gnt_id ? p1_req_we    : p0_req_we;
  assign sel_addr  = gnt_id ? p1_req_addr  : p0_req_addr;
  assign sel_wdata = gnt_id ? p1_req_wdata : p0_req_wdata;
  assign sel_rom   = ({1'b0, sel_addr} < ROM_LIMIT);

  assign busy = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, arbitration and request/response handshakes.
  always_comb begin
    state_d      = state_q;
    gnt_id       = 1'b0;
    req_hs       = 1'b0;
    rsp_hs       = 1'b0;
    p0_req_ready = 1'b0;
    p1_req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the port that did not win last time goes first.
        if (p0_req_valid && p1_req_valid) gnt_id = ~last_grant;
        else                              gnt_id = p1_req_valid;
        // Ready is gated by rst_n so nothing is offered while reset is held.
        if (rst_n && (p0_req_valid || p1_req_valid)) begin
          req_hs       = 1'b1;
          p0_req_ready = ~gnt_id;
          p1_req_ready = gnt_id;
          state_d      = ACCESS;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        rsp_hs = lat_id ? (p1_rsp_valid && p1_rsp_ready)
                        : (p0_rsp_valid && p0_rsp_ready);
        if (rsp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, registered memory drive and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant     <= 1'b1;
      lat_id         <= 1'b0;
      lat_we         <= 1'b0;
      lat_rom        <= 1'b0;
      mem_address    <= '0;
      mem_w_data     <= '0;
      mem_ctrl_mem_w <= 1'b0;
      mem_ctrl_mem_r <= 1'b0;
      p0_rsp_valid   <= 1'b0;
      p0_rsp_rdata   <= '0;
      p0_rsp_err     <= 1'b0;
      p1_rsp_valid   <= 1'b0;
      p1_rsp_rdata   <= '0;
      p1_rsp_err     <= 1'b0;
    end else begin
      // Memory drive is live for the single ACCESS cycle only.
      mem_address    <= '0;
      mem_w_data     <= '0;
      mem_ctrl_mem_w <= 1'b0;
      mem_ctrl_mem_r <= 1'b0;

      if (req_hs) begin
        last_grant     <= gnt_id;
        lat_id         <= gnt_id;
        lat_we         <= sel_we;
        lat_rom        <= sel_rom;
        mem_address    <= sel_addr;
        mem_ctrl_mem_r <= ~sel_we;
        mem_ctrl_mem_w <= sel_we & ~sel_rom;
        mem_w_data     <= (sel_we && !sel_rom) ? sel_wdata : '0;
      end

      if (state_q == ACCESS) begin
        if (lat_id) begin
          p1_rsp_valid <= 1'b1;
          p1_rsp_rdata <= lat_we ? '0 : mem_r_data;
          p1_rsp_err   <= lat_we & lat_rom;
        end else begin
          p0_rsp_valid <= 1'b1;
          p0_rsp_rdata <= lat_we ? '0 : mem_r_data;
          p0_rsp_err   <= lat_we & lat_rom;
        end
      end

      if (rsp_hs) begin
        if (lat_id) p1_rsp_valid <= 1'b0;
        else        p0_rsp_valid <= 1'b0;
      end
    end
  end

`ifdef DMEM_ARBITER_GRANT_CNT_EN
  // Saturating grant counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_0 <= '0;
      grant_cnt_1 <= '0;
    end else if (req_hs) begin
      if (!gnt_id && (grant_cnt_0 != '1)) grant_cnt_0 <= grant_cnt_0 + CNT_WIDTH'(1);
      if ( gnt_id && (grant_cnt_1 != '1)) grant_cnt_1 <= grant_cnt_1 + CNT_WIDTH'(1);
    end
  end
`else
  assign grant_cnt_0 = '0;
  assign grant_cnt_1 = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a table of single transactions with
// hand-computed results, then hand-written round-robin, backpressure and
// mid-access reset sequences. A behavioural data_memory lives in the bench.

module tb_dmem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned RD = 16;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          p0_req_valid = 1'b0, p0_req_we = 1'b0;
  logic [AW-1:0] p0_req_addr = '0;
  logic [DW-1:0] p0_req_wdata = '0;
  logic          p0_rsp_ready = 1'b1;
  logic          p1_req_valid = 1'b0, p1_req_we = 1'b0;
  logic [AW-1:0] p1_req_addr = '0;
  logic [DW-1:0] p1_req_wdata = '0;
  logic          p1_rsp_ready = 1'b1;
  logic          p0_req_ready, p0_rsp_valid, p0_rsp_err;
  logic          p1_req_ready, p1_rsp_valid, p1_rsp_err;
  logic [DW-1:0] p0_rsp_rdata, p1_rsp_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_w_data, mem_r_data;
  logic          mem_ctrl_mem_w, mem_ctrl_mem_r, busy;
  logic [CW-1:0] grant_cnt_0, grant_cnt_1;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROM_DEPTH(RD), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_ready(p0_rsp_ready), .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_ready(p1_rsp_ready), .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .mem_address(mem_address), .mem_w_data(mem_w_data), .mem_r_data(mem_r_data),
    .mem_ctrl_mem_w(mem_ctrl_mem_w), .mem_ctrl_mem_r(mem_ctrl_mem_r),
    .busy(busy), .grant_cnt_0(grant_cnt_0), .grant_cnt_1(grant_cnt_1)
  );

  // Behavioural data_memory: combinational read, write on rising edge.
  logic [DW-1:0] tb_mem [256];
  assign mem_r_data = tb_mem[mem_address];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= {4{8'(i)}};
      tb_mem[5]    <= 32'hDEADBEEF;
      tb_mem[2]    <= 32'hA5A50002;
    end else if (mem_ctrl_mem_w) begin
      tb_mem[mem_address] <= mem_w_data;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_last = 1'b1;
  int   cnt0 = 0;
  int   cnt1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_grant(input logic id);
    exp_last = id;
    if (id) cnt1++; else cnt0++;
  endtask

  task automatic chk_counters(input string name);
    int e0, e1;
`ifdef DMEM_ARBITER_GRANT_CNT_EN
    e0 = cnt0; e1 = cnt1;
`else
    e0 = 0; e1 = 0;
`endif
    chk({name, "_cnt0"}, 32'(grant_cnt_0), 32'(e0));
    chk({name, "_cnt1"}, 32'(grant_cnt_1), 32'(e1));
  endtask

  typedef struct {
    logic          v0, we0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1, we1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          exp_id;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    logic          exp_memw;
  } vec_t;

  vec_t vecs [12];

  // One full request/access/response round trip with rsp_ready high.
  task automatic run_vec(input int idx, input vec_t v);
    logic [AW-1:0] ea;
    string tag;
    tag = $sformatf("v%0d", idx);
    ea  = v.exp_id ? v.a1 : v.a0;
    @(negedge clk);
    p0_req_valid = v.v0; p0_req_we = v.we0; p0_req_addr = v.a0; p0_req_wdata = v.d0;
    p1_req_valid = v.v1; p1_req_we = v.we1; p1_req_addr = v.a1; p1_req_wdata = v.d1;
    #1;
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    chk({tag, "_p0_ready"}, 32'(p0_req_ready), 32'(!v.exp_id));
    chk({tag, "_p1_ready"}, 32'(p1_req_ready), 32'(v.exp_id));
    note_grant(v.exp_id);
    @(negedge clk);
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    #1;
    chk({tag, "_acc_addr"}, 32'(mem_address), 32'(ea));
    chk({tag, "_acc_memr"}, 32'(mem_ctrl_mem_r), 32'(!(v.exp_id ? v.we1 : v.we0)));
    chk({tag, "_acc_memw"}, 32'(mem_ctrl_mem_w), 32'(v.exp_memw));
    if (v.exp_memw) chk({tag, "_acc_wdata"}, mem_w_data, v.exp_id ? v.d1 : v.d0);
    @(negedge clk); #1;
    chk({tag, "_rsp_valid"}, {p1_rsp_valid, p0_rsp_valid}, v.exp_id ? 32'd2 : 32'd1);
    chk({tag, "_rdata"}, v.exp_id ? p1_rsp_rdata : p0_rsp_rdata, v.exp_rdata);
    chk({tag, "_err"}, 32'(v.exp_id ? p1_rsp_err : p0_rsp_err), 32'(v.exp_err));
    chk({tag, "_strobes_off"}, {mem_ctrl_mem_r, mem_ctrl_mem_w}, 32'd0);
  endtask

  initial begin
    logic exp_id;
    int   g0, g1, prev;
    logic drop0, drop1;

    //            v0  we0  a0     d0            v1  we1  a1     d1            id  rdata         err  memw
    vecs[0]  = '{1'b1,1'b0,8'h05,32'h0,        1'b0,1'b0,8'h00,32'h0,        1'b0,32'hDEADBEEF,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b0,8'h00,32'h0,        1'b1,1'b1,8'h13,32'h12345678, 1'b1,32'h0,       1'b0,1'b1};
    vecs[2]  = '{1'b0,1'b0,8'h00,32'h0,        1'b1,1'b0,8'h13,32'h0,        1'b1,32'h12345678,1'b0,1'b0};
    vecs[3]  = '{1'b1,1'b1,8'h02,32'hFFFFFFFF, 1'b0,1'b0,8'h00,32'h0,        1'b0,32'h0,       1'b1,1'b0};
    vecs[4]  = '{1'b1,1'b0,8'h02,32'h0,        1'b0,1'b0,8'h00,32'h0,        1'b0,32'hA5A50002,1'b0,1'b0};
    vecs[5]  = '{1'b1,1'b0,8'h05,32'h0,        1'b1,1'b0,8'h13,32'h0,        1'b1,32'h12345678,1'b0,1'b0};
    vecs[6]  = '{1'b1,1'b0,8'h05,32'h0,        1'b1,1'b0,8'h13,32'h0,        1'b0,32'hDEADBEEF,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b0,8'h00,32'h0,        1'b1,1'b1,8'h10,32'hCAFE0010, 1'b1,32'h0,       1'b0,1'b1};
    vecs[8]  = '{1'b1,1'b1,8'h0F,32'h00000001, 1'b0,1'b0,8'h00,32'h0,        1'b0,32'h0,       1'b1,1'b0};
    vecs[9]  = '{1'b0,1'b0,8'h00,32'h0,        1'b1,1'b0,8'h10,32'h0,        1'b1,32'hCAFE0010,1'b0,1'b0};
    vecs[10] = '{1'b1,1'b0,8'h0F,32'h0,        1'b0,1'b0,8'h00,32'h0,        1'b0,32'h0F0F0F0F,1'b0,1'b0};
    vecs[11] = '{1'b1,1'b0,8'hFF,32'h0,        1'b0,1'b0,8'h00,32'h0,        1'b0,32'hFFFFFFFF,1'b0,1'b0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {busy, mem_ctrl_mem_r, mem_ctrl_mem_w, p0_req_ready, p1_req_ready,
                        p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err}, 32'd0);
    chk("rst_mem_addr", 32'(mem_address), 32'd0);
    chk("rst_mem_wdata", mem_w_data, 32'd0);
    chk("rst_rdata", p0_rsp_rdata | p1_rsp_rdata, 32'd0);
    chk_counters("rst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);
    chk_counters("table");

    // Round-robin: both ports hold valid for six requests each.
    p0_req_we = 1'b0; p0_req_addr = 8'h05;
    p1_req_we = 1'b0; p1_req_addr = 8'h13;
    g0 = 0; g1 = 0; prev = -1; drop0 = 1'b0; drop1 = 1'b0;
    @(negedge clk);
    p0_req_valid = 1'b1; p1_req_valid = 1'b1;
    for (int c = 0; c < 100 && (g0 < 6 || g1 < 6); c++) begin
      if (c > 0) @(negedge clk);
      if (drop0) p0_req_valid = 1'b0;
      if (drop1) p1_req_valid = 1'b0;
      #1;
      chk("rr_onehot", 32'(p0_req_ready & p1_req_ready), 32'd0);
      if (p0_req_ready || p1_req_ready) begin
        exp_id = (p0_req_valid && p1_req_valid) ? !exp_last : p1_req_valid;
        chk("rr_grant", 32'(p1_req_ready), 32'(exp_id));
        if (prev >= 0) chk("rr_spacing", 32'(c - prev), 32'd3);
        prev = c;
        note_grant(exp_id);
        if (exp_id) begin g1++; drop1 = (g1 >= 6); end
        else        begin g0++; drop0 = (g0 >= 6); end
      end
    end
    chk("rr_done", 32'(g0 * 16 + g1), 32'(6 * 16 + 6));
    @(negedge clk); p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rr_idle", 32'(busy), 32'd0);
    chk_counters("rr");

    // Response backpressure: p0 response held while p1 waits.
    @(negedge clk);
    p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 8'h05; p0_rsp_ready = 1'b0;
    #1;
    chk("bp_p0_ready", 32'(p0_req_ready), 32'd1);
    note_grant(1'b0);
    @(negedge clk);
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 8'h13;
    #1;
    chk("bp_acc_p1_ready", 32'(p1_req_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      chk("bp_hold_p1_ready", 32'(p1_req_ready), 32'd0);
      chk("bp_hold_valid", {p1_rsp_valid, p0_rsp_valid}, 32'd1);
      chk("bp_hold_rdata", p0_rsp_rdata, 32'hDEADBEEF);
    end
    @(negedge clk);
    p0_rsp_ready = 1'b1;
    #1;
    chk("bp_release_valid", 32'(p0_rsp_valid), 32'd1);
    chk("bp_release_p1_ready", 32'(p1_req_ready), 32'd0);
    @(negedge clk); #1;
    chk("bp_after_valid", 32'(p0_rsp_valid), 32'd0);
    chk("bp_p1_granted", 32'(p1_req_ready), 32'd1);
    note_grant(1'b1);
    @(negedge clk);
    p1_req_valid = 1'b0;
    #1;
    chk("bp_p1_memr", 32'(mem_ctrl_mem_r), 32'd1);
    @(negedge clk); #1;
    chk("bp_p1_rsp", 32'(p1_rsp_valid), 32'd1);
    chk("bp_p1_rdata", p1_rsp_rdata, 32'h12345678);
    @(negedge clk);

    // Reset in the middle of a p1 read access.
    p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_addr = 8'h10;
    #1;
    chk("mr_p1_ready", 32'(p1_req_ready), 32'd1);
    note_grant(1'b1);
    @(negedge clk); #1;
    chk("mr_access", {busy, mem_ctrl_mem_r}, 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    exp_last = 1'b1; cnt0 = 0; cnt1 = 0;
    chk("mr_outputs", {busy, mem_ctrl_mem_r, mem_ctrl_mem_w, p0_req_ready, p1_req_ready,
                       p0_rsp_valid, p1_rsp_valid}, 32'd0);
    chk("mr_mem_addr", 32'(mem_address), 32'd0);
    chk_counters("mr");
    @(negedge clk);
    rst_n = 1'b1;
    p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_addr = 8'h05;
    p1_req_addr = 8'h13;
    #1;
    chk("mr_tie_p0", {p1_req_ready, p0_req_ready}, 32'd1);
    note_grant(1'b0);
    @(negedge clk);
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    @(negedge clk); #1;
    chk("mr_p0_rsp", {p1_rsp_valid, p0_rsp_valid}, 32'd1);
    chk("mr_p0_rdata", p0_rsp_rdata, 32'hDEADBEEF);
    @(negedge clk); #1;
    chk_counters("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
